wisc_instr_encoder: RTL and testbench

// Packs field-level instruction requests (opcode, regs, func, immediate) into 16-bit WISC

---
 rtl/wisc_instr_encoder_if.sv | 32 +++
 rtl/wisc_instr_encoder.sv | 140 ++++++++++++++
 tb/tb_wisc_instr_encoder.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wisc_instr_encoder_if.sv
// Bus bundle for wisc_instr_encoder: request side, memory write side and status.
// master drives requests and mem_ready; slave is the encoder itself.
interface wisc_instr_encoder_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_op;
   logic [2:0]        in_rs;
   logic [2:0]        in_rt;
   logic [2:0]        in_rd;
   logic [1:0]        in_func;
   logic [10:0]       in_imm;
   logic              mem_wr_en;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_data;
   logic              err;
   logic              done;

   modport master (
      output start, base_addr, in_valid, in_op, in_rs, in_rt, in_rd, in_func, in_imm, mem_ready,
      input  in_ready, mem_wr_en, mem_addr, mem_data, err, done
   );

   modport slave (
      input  start, base_addr, in_valid, in_op, in_rs, in_rt, in_rd, in_func, in_imm, mem_ready,
      output in_ready, mem_wr_en, mem_addr, mem_data, err, done
   );
endinterface

// File: rtl/wisc_instr_encoder.sv
// Encodes field-level WISC instruction requests into 16-bit words, buffers them in a
// small FIFO and writes them to instruction memory at consecutive byte addresses.
module wisc_instr_encoder #(
   parameter int ADDR_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   wisc_instr_encoder_if.slave  bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [15:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_addr;
   logic              r_err;

   logic        w_full;
   logic        w_empty;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic        w_bad;
   logic [15:0] w_word;
   logic        w_s5_ok;
   logic        w_u5_ok;
   logic        w_s8_ok;
   logic        w_u8_ok;

   assign w_full   = (r_count == DEPTH_C);
   assign w_empty  = (r_count == '0);
   assign w_accept = bus.in_valid && bus.in_ready;
   assign w_push   = w_accept && !w_bad;
   assign w_pop    = !w_empty && bus.mem_ready;

   // Range checks: the upper immediate bits must be a pure sign or zero extension.
   assign w_s5_ok = (&bus.in_imm[10:4]) || !(|bus.in_imm[10:4]);
   assign w_u5_ok = !(|bus.in_imm[10:5]);
   assign w_s8_ok = (&bus.in_imm[10:7]) || !(|bus.in_imm[10:7]);
   assign w_u8_ok = !(|bus.in_imm[10:8]);

   always_comb begin
      w_word = '0;
      w_bad  = 1'b0;
      casez (bus.in_op)
         5'b000??: w_word = {bus.in_op, 11'b0};
         5'b00100, 5'b00110: w_word = {bus.in_op, bus.in_imm};
         5'b011??, 5'b11000, 5'b00101, 5'b00111: begin
            w_word = {bus.in_op, bus.in_rs, bus.in_imm[7:0]};
            w_bad  = !w_s8_ok;
         end
         5'b10010: begin
            w_word = {bus.in_op, bus.in_rs, bus.in_imm[7:0]};
            w_bad  = !w_u8_ok;
         end
         5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin
            w_word = {bus.in_op, bus.in_rs, bus.in_rd, bus.in_imm[4:0]};
            w_bad  = !w_s5_ok;
         end
         5'b01010, 5'b01011, 5'b101??: begin
            w_word = {bus.in_op, bus.in_rs, bus.in_rd, bus.in_imm[4:0]};
            w_bad  = !w_u5_ok;
         end
         5'b11001: w_word = {bus.in_op, bus.in_rs, 3'b000, bus.in_rd, 2'b00};
         5'b11010, 5'b11011, 5'b111??: w_word = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_func};
         default: w_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // DRAIN ends on the same edge that pops the last word, so done follows the HALT pop directly.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.start) begin
         w_state_nxt = S_RUN;
      end else begin
         case (r_state)
            S_RUN:   if (w_push && (bus.in_op == 5'b00000)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_empty || (w_pop && (r_count == ONE_C))) w_state_nxt = S_HALTED;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_addr   <= '0;
         r_err    <= 1'b0;
      end else begin
         r_err <= w_accept && w_bad;
         if (bus.start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= bus.base_addr;
         end else begin
            if (w_push) begin
               r_mem[r_wr_ptr] <= w_word;
               r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
               r_addr   <= r_addr + ADDR_W'(2);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign bus.in_ready  = (r_state == S_RUN) && !w_full;
   assign bus.mem_wr_en = !w_empty;
   assign bus.mem_data  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign bus.mem_addr  = r_addr;
   assign bus.err       = r_err;
   assign bus.done      = (r_state == S_HALTED);
endmodule

// File: tb/tb_wisc_instr_encoder.sv
// Bench for wisc_instr_encoder: vector table, directed corner sequences and random
// requests, all checked against a field-rule encoding model and an expected-write queue.
module tb_wisc_instr_encoder;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   wisc_instr_encoder_if #(.ADDR_W(16)) bus ();

   wisc_instr_encoder #(.ADDR_W(16), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  op;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [2:0]  rd;
      logic [1:0]  func;
      logic [10:0] imm;
      bit          err;
      logic [15:0] word;
   } vec_t;

   vec_t vt[$];
   int   exp_q[$];
   int   exp_addr;
   bit   exp_err;
   bit   m_started;
   bit   m_halt;
   bit   rnd_ready;
   int   obs_wr_cnt;
   int   obs_err_cnt;
   int   obs_last_data;
   int   obs_last_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Encoding model built from the opcode table with plain integer arithmetic.
   function automatic void model_enc(input int op, input int rs, input int rt, input int rd,
                                     input int func, input int imm, output bit bad, output int word);
      int s;
      s    = (imm >= 1024) ? imm - 2048 : imm;
      bad  = 1'b0;
      word = op * 2048;
      case (op)
         0, 1, 2, 3: ;
         4, 6: begin
            bad  = (s < -1024) || (s > 1023);
            word = word + imm;
         end
         5, 7, 12, 13, 14, 15, 24: begin
            bad  = (s < -128) || (s > 127);
            word = word + rs * 256 + (s & 255);
         end
         18: begin
            bad  = (imm > 255);
            word = word + rs * 256 + (imm % 256);
         end
         8, 9, 16, 17, 19: begin
            bad  = (s < -16) || (s > 15);
            word = word + rs * 256 + rd * 32 + (s & 31);
         end
         10, 11, 20, 21, 22, 23: begin
            bad  = (imm > 31);
            word = word + rs * 256 + rd * 32 + (imm % 32);
         end
         25: word = word + rs * 256 + rd * 4;
         26, 27, 28, 29, 30, 31: word = word + rs * 256 + rt * 32 + rd * 4 + func;
         default: bad = 1'b1;
      endcase
   endfunction

   task automatic mon_step();
      bit m_ready;
      bit nerr;
      bit bad;
      int w;
      if (!rst_n) begin
         exp_q.delete();
         exp_addr  = 0;
         exp_err   = 1'b0;
         m_started = 1'b0;
         m_halt    = 1'b0;
         return;
      end
      m_ready = m_started && !m_halt && (exp_q.size() < 4);
      chk("err", 32'(bus.err), 32'(exp_err));
      chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
      chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(exp_q.size() != 0));
      chk("mem_data", 32'(bus.mem_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
      chk("done", 32'(bus.done), 32'(m_halt && (exp_q.size() == 0)));
      if (bus.err) obs_err_cnt++;
      nerr = 1'b0;
      if (bus.start) begin
         exp_q.delete();
         exp_addr  = int'(bus.base_addr);
         m_started = 1'b1;
         m_halt    = 1'b0;
      end else begin
         if ((exp_q.size() != 0) && bus.mem_ready) begin
            obs_wr_cnt++;
            obs_last_data = int'(bus.mem_data);
            obs_last_addr = int'(bus.mem_addr);
            void'(exp_q.pop_front());
            exp_addr = (exp_addr + 2) & 32'hFFFF;
         end
         if (bus.in_valid && m_ready) begin
            model_enc(int'(bus.in_op), int'(bus.in_rs), int'(bus.in_rt), int'(bus.in_rd),
                      int'(bus.in_func), int'(bus.in_imm), bad, w);
            if (bad) nerr = 1'b1;
            else begin
               exp_q.push_back(w);
               if (bus.in_op == 5'd0) m_halt = 1'b1;
            end
         end
      end
      exp_err = nerr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) bus.mem_ready = 1'($urandom % 2);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_start(input logic [15:0] base);
      bus.start     = 1'b1;
      bus.base_addr = base;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic [1:0] func, input logic [10:0] imm);
      bit ok;
      bus.in_op   = op;
      bus.in_rs   = rs;
      bus.in_rt   = rt;
      bus.in_rd   = rd;
      bus.in_func = func;
      bus.in_imm  = imm;
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int base_wr;
      int base_err;
      int v;
      bit got;
      n_checks = 0; n_pass = 0;
      obs_wr_cnt = 0; obs_err_cnt = 0; obs_last_data = 0; obs_last_addr = 0;
      exp_addr = 0; exp_err = 1'b0; m_started = 1'b0; m_halt = 1'b0; rnd_ready = 1'b0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.base_addr = '0; bus.in_valid = 1'b0; bus.in_op = '0;
      bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0; bus.in_func = '0; bus.in_imm = '0;
      bus.mem_ready = 1'b0;

      vt.push_back('{5'h08, 3'd1, 3'd0, 3'd2, 2'd0, 11'h7FD, 1'b0, 16'h415D});
      vt.push_back('{5'h1B, 3'd1, 3'd2, 3'd3, 2'd0, 11'h000, 1'b0, 16'hD94C});
      vt.push_back('{5'h04, 3'd0, 3'd0, 3'd0, 2'd0, 11'h7FE, 1'b0, 16'h27FE});
      vt.push_back('{5'h18, 3'd7, 3'd0, 3'd0, 2'd0, 11'h780, 1'b0, 16'hC780});
      vt.push_back('{5'h08, 3'd1, 3'd0, 3'd2, 2'd0, 11'h010, 1'b1, 16'h0000});
      vt.push_back('{5'h0A, 3'd1, 3'd0, 3'd2, 2'd0, 11'h7FF, 1'b1, 16'h0000});
      vt.push_back('{5'h0A, 3'd3, 3'd0, 3'd4, 2'd0, 11'h01F, 1'b0, 16'h539F});
      vt.push_back('{5'h12, 3'd5, 3'd0, 3'd0, 2'd0, 11'h0FF, 1'b0, 16'h95FF});
      vt.push_back('{5'h12, 3'd5, 3'd0, 3'd0, 2'd0, 11'h100, 1'b1, 16'h0000});
      vt.push_back('{5'h0C, 3'd2, 3'd0, 3'd0, 2'd0, 11'h07F, 1'b0, 16'h627F});
      vt.push_back('{5'h0D, 3'd2, 3'd0, 3'd0, 2'd0, 11'h080, 1'b1, 16'h0000});
      vt.push_back('{5'h0E, 3'd2, 3'd0, 3'd0, 2'd0, 11'h77F, 1'b1, 16'h0000});
      vt.push_back('{5'h19, 3'd6, 3'd5, 3'd1, 2'd3, 11'h7FF, 1'b0, 16'hCE04});
      vt.push_back('{5'h01, 3'd7, 3'd7, 3'd7, 2'd3, 11'h7FF, 1'b0, 16'h0800});
      vt.push_back('{5'h10, 3'd1, 3'd0, 3'd7, 2'd0, 11'h7F0, 1'b0, 16'h81F0});
      vt.push_back('{5'h11, 3'd1, 3'd0, 3'd7, 2'd0, 11'h7EF, 1'b1, 16'h0000});
      vt.push_back('{5'h07, 3'd4, 3'd0, 3'd0, 2'd0, 11'h7FF, 1'b0, 16'h3CFF});
      vt.push_back('{5'h1D, 3'd1, 3'd2, 3'd3, 2'd3, 11'h000, 1'b0, 16'hE94F});
      vt.push_back('{5'h06, 3'd0, 3'd0, 3'd0, 2'd0, 11'h3FF, 1'b0, 16'h33FF});
      vt.push_back('{5'h16, 3'd0, 3'd6, 3'd5, 2'd0, 11'h000, 1'b0, 16'hB0A0});

      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
      join_none

      // Reset values
      idle(2);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_data", 32'(bus.mem_data), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      idle(2);
      chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

      // Single ADDI: head visible one cycle after accept
      do_start(16'h0100);
      send(5'h08, 3'd1, 3'd0, 3'd2, 2'd0, 11'h7FD);
      @(negedge clk);
      chk("lat_wr_en", 32'(bus.mem_wr_en), 32'd1);
      chk("lat_data", 32'(bus.mem_data), 32'h415D);
      chk("lat_addr", 32'(bus.mem_addr), 32'h0100);
      tick();
      bus.mem_ready = 1'b1;
      idle(2);

      // ADD then J at consecutive addresses
      do_start(16'h0200);
      send(5'h1B, 3'd1, 3'd2, 3'd3, 2'd0, 11'h000);
      idle(2);
      chk("add_data", 32'(obs_last_data), 32'hD94C);
      chk("add_addr", 32'(obs_last_addr), 32'h0200);
      send(5'h04, 3'd0, 3'd0, 3'd0, 2'd0, 11'h7FE);
      idle(2);
      chk("j_data", 32'(obs_last_data), 32'h27FE);
      chk("j_addr", 32'(obs_last_addr), 32'h0202);

      // Out-of-range immediates
      base_wr = obs_wr_cnt;
      send(5'h08, 3'd1, 3'd0, 3'd2, 2'd0, 11'h010);
      @(negedge clk);
      chk("addi16_err", 32'(bus.err), 32'd1);
      tick();
      send(5'h0A, 3'd1, 3'd0, 3'd2, 2'd0, 11'h7FF);
      @(negedge clk);
      chk("xori_m1_err", 32'(bus.err), 32'd1);
      idle(3);
      chk("rej_no_write", 32'(obs_wr_cnt), 32'(base_wr));
      chk("rej_addr_hold", 32'(bus.mem_addr), 32'h0204);

      // Vector table
      foreach (vt[i]) begin
         base_wr  = obs_wr_cnt;
         base_err = obs_err_cnt;
         send(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].func, vt[i].imm);
         idle(3);
         if (vt[i].err) begin
            chk($sformatf("vec%0d_err", i), 32'(obs_err_cnt), 32'(base_err + 1));
            chk($sformatf("vec%0d_nowr", i), 32'(obs_wr_cnt), 32'(base_wr));
         end else begin
            chk($sformatf("vec%0d_wr", i), 32'(obs_wr_cnt), 32'(base_wr + 1));
            chk($sformatf("vec%0d_word", i), 32'(obs_last_data), 32'(vt[i].word));
         end
      end

      // Backpressure: FIFO fills, fifth request waits, head holds
      do_start(16'h0300);
      bus.mem_ready = 1'b0;
      base_wr = obs_wr_cnt;
      for (int k = 1; k <= 4; k++) send(5'h12, 3'd1, 3'd0, 3'd0, 2'd0, 11'(k));
      bus.in_op = 5'h12; bus.in_rs = 3'd1; bus.in_imm = 11'd5; bus.in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("full_in_ready", 32'(bus.in_ready), 32'd0);
         chk("full_head", 32'(bus.mem_data), 32'h9101);
      end
      tick();
      bus.mem_ready = 1'b1;
      send(5'h12, 3'd1, 3'd0, 3'd0, 2'd0, 11'd5);
      idle(8);
      chk("bp_count", 32'(obs_wr_cnt), 32'(base_wr + 5));
      chk("bp_last", 32'(obs_last_data), 32'h9105);

      // Address wrap
      do_start(16'hFFFE);
      send(5'h01, 3'd0, 3'd0, 3'd0, 2'd0, 11'h000);
      idle(2);
      chk("wrap_addr0", 32'(obs_last_addr), 32'hFFFE);
      send(5'h01, 3'd0, 3'd0, 3'd0, 2'd0, 11'h000);
      idle(2);
      chk("wrap_addr1", 32'(obs_last_addr), 32'h0000);

      // Asynchronous reset with words pending
      do_start(16'h0400);
      bus.mem_ready = 1'b0;
      send(5'h01, 3'd0, 3'd0, 3'd0, 2'd0, 11'h000);
      send(5'h01, 3'd0, 3'd0, 3'd0, 2'd0, 11'h000);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_wr_en", 32'(bus.mem_wr_en), 32'd0);
      chk("arst_data", 32'(bus.mem_data), 32'd0);
      chk("arst_addr", 32'(bus.mem_addr), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      bus.mem_ready = 1'b1;
      idle(2);

      // Random requests with random memory backpressure
      do_start(16'($urandom) & 16'hFFFE);
      rnd_ready = 1'b1;
      for (int n = 0; n < 150; n++) begin
         case ($urandom % 4)
            0:       v = int'($urandom % 2048);
            1:       v = int'($urandom_range(0, 40)) - 20;
            2:       v = int'($urandom_range(0, 300)) - 150;
            default: v = int'($urandom_range(0, 300));
         endcase
         send(5'($urandom_range(1, 31)), 3'($urandom), 3'($urandom), 3'($urandom),
              2'($urandom), v[10:0]);
         if ($urandom % 4 == 0) idle(int'($urandom % 3));
      end
      rnd_ready = 1'b0;
      bus.mem_ready = 1'b1;
      idle(8);

      // LBI then HALT, done, re-arm
      base_wr = obs_wr_cnt;
      send(5'h18, 3'd7, 3'd0, 3'd0, 2'd0, 11'h780);
      send(5'h00, 3'd0, 3'd0, 3'd0, 2'd0, 11'h000);
      @(negedge clk);
      chk("halt_in_ready", 32'(bus.in_ready), 32'd0);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bus.done) got = 1'b1;
      end
      chk("halt_done", 32'(got), 32'd1);
      chk("halt_writes", 32'(obs_wr_cnt), 32'(base_wr + 2));
      chk("halt_word", 32'(obs_last_data), 32'h0000);
      tick();
      do_start(16'h0500);
      @(negedge clk);
      chk("rearm_done", 32'(bus.done), 32'd0);
      chk("rearm_in_ready", 32'(bus.in_ready), 32'd1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
